sp_mem_pipe: RTL and testbench
==============================

# sp_mem_pipe

Parametrised single-port synchronous memory, successor to the fixed-size `memory` block. It adds byte-write enables, a configurable read latency of 1 or 2 cycles and a selectable read-during-write mode. It also adds post-reset zero-initialisation and out-of-range address detection. It sits behind a request/ready interface and is the RAM primitive for the team's buffer and register-file blocks.

## Interface
Parameters:
- DATA_W, 32, word width; must be a multiple of 8.
- DEPTH, 16, number of words; need not be a power of 2.
- ADDR_W, $clog2(DEPTH) (min 1), address width.
- RD_LAT, 1, response latency in cycles; legal values are 1 and 2.
- RDW_MODE, 0, read-during-write result. 0 = READ_FIRST (old word), 1 = WRITE_FIRST (merged new word).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  request valid.
- wr_enb  in  1  1 = write, 0 = read; sampled with en.
- byte_enb  in  DATA_W/8  per-byte write enable; bit i covers wr_data[8i+7:8i]; ignored for reads.
- addr  in  ADDR_W  word address.
- wr_data  in  DATA_W  write data.
- ready  out  1  block accepts requests.
- rd_data  out  DATA_W  response data.
- rd_valid  out  1  rd_data valid, one cycle per accepted request.
- addr_err  out  1  accepted request had addr >= DEPTH; aligned with rd_valid.

## Operation
- FSM states:
  - INIT: clears the array, ready=0.
  - RUN: services requests, ready=1.
- Reset: rst sampled high puts the FSM in INIT and sets the sweep counter to 0. It also clears ready, rd_valid, addr_err, rd_data (all 0) and flushes the response pipeline. Reset asserted mid-operation or mid-INIT drops in-flight responses and restarts the sweep from 0.
- INIT: each edge with rst low writes 0 to mem[cnt] and increments cnt. The edge that writes cnt=DEPTH-1 moves the FSM to RUN.
- Acceptance: a request is accepted at an edge where en && ready. Requests presented while ready=0 are ignored: no write and no response.
- Write: for each byte i with byte_enb[i]=1, mem[addr] byte i is replaced by the wr_data byte. byte_enb=0 leaves the word unchanged but still produces a response.
- Every accepted request, read or write, produces exactly one rd_valid pulse.
  - Read: rd_data = mem[addr].
  - Write, RDW_MODE=0: rd_data = word before the write.
  - Write, RDW_MODE=1: rd_data = word after the byte merge.
- Out of range (addr >= DEPTH): the write is dropped and the array is unchanged. The response is rd_data=0 with addr_err=1. addr_err is 0 on all in-range responses.
- rd_data holds its last value while rd_valid=0.
- One operation per cycle; back-to-back requests are supported at full rate with no bubbles.

## Timing
- Request accepted at edge k:
  - RD_LAT=1: rd_valid/rd_data/addr_err are registered at edge k.
  - RD_LAT=2: they are registered at edge k+1.
  - Each response is high for exactly one cycle.
- A write accepted at edge k is visible to a read accepted at edge k+1.
- ready rises exactly DEPTH edges after the first edge with rst low, then stays 1 until the next reset.
- The response pipeline holds RD_LAT entries and has no backpressure; the consumer must always accept.
- With rst and en both high at the same edge, reset wins: no write and no response.

## Test plan
- Reset/init (DATA_W=32, DEPTH=12, RD_LAT=1):
  - Hold rst 3 cycles, release, and count edges -> ready rises after exactly 12 edges.
  - Read addresses 0..11 -> all 0x00000000, addr_err=0.
- Byte enables: write 0xAABBCCDD to addr 5 with byte_enb=4'b1111, then write 0x11223344 with byte_enb=4'b0101, then read addr 5 -> 0xAA22CC44.
- Read-during-write: mem[3]=0x12345678, write 0xCAFEF00D with all bytes enabled.
  - RDW_MODE=0 -> write response rd_data=0x12345678.
  - RDW_MODE=1 -> rd_data=0xCAFEF00D.
  - Either mode: subsequent read -> 0xCAFEF00D.
- Latency/back-to-back: RD_LAT=2, reads to addresses 1,2,3 on consecutive edges k,k+1,k+2 -> rd_valid high in cycles after edges k+1,k+2,k+3 carrying mem[1],mem[2],mem[3] in order.
- Out of range (DEPTH=12):
  - Write 0xFFFFFFFF to addr 13 -> addr_err=1, rd_data=0, and addresses 0..11 unchanged.
  - Read addr 15 -> rd_valid=1, addr_err=1, rd_data=0.
- Reset mid-operation:
  - Assert rst while a read is one cycle from its response -> no rd_valid pulse, and ready=0 for 12 edges after release.
  - All words 0 afterwards, including one written to 0x5A5A5A5A before the reset.

Source files
------------

// File: rtl/sp_mem_pipe.sv
// sp_mem_pipe: single-port RAM with byte enables, 1/2-cycle read latency and post-reset clear
module sp_mem_pipe #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = DEPTH > 1 ? $clog2(DEPTH) : 1,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                wr_enb,
  input  logic [DATA_W/8-1:0] byte_enb,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic                addr_err
);
  typedef enum logic {INIT, RUN} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] mask, old, merged, resp, d1_q, d1_d, d2_q, d2_d;
  logic in_rng, acc, v1_q, v1_d, e1_q, e1_d, v2_q, v2_d, e2_q, e2_d;
  // request decode, byte merge, sweep control and response pipeline next-state
  always_comb begin
    mask = '0;
    for (int i = 0; i < DATA_W/8; i++) mask[8*i +: 8] = {8{byte_enb[i]}};
    in_rng = {1'b0, addr} < (ADDR_W+1)'(DEPTH);
    acc = en && state_q == RUN;
    old = in_rng ? mem[addr] : '0;
    merged = (old & ~mask) | (wr_data & mask);
    resp = !in_rng ? '0 : (wr_enb && RDW_MODE == 1) ? merged : old;
    state_d = (state_q == INIT && cnt_q == ADDR_W'(DEPTH-1)) ? RUN : state_q;
    cnt_d = state_q == INIT ? cnt_q + 1'b1 : cnt_q;
    v1_d = acc;
    d1_d = acc ? resp : d1_q;
    e1_d = acc && !in_rng;
    v2_d = v1_q;
    d2_d = v1_q ? d1_q : d2_q;
    e2_d = e1_q;
  end
  // control and response registers; reset flushes everything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      v1_q    <= 1'b0;
      d1_q    <= '0;
      e1_q    <= 1'b0;
      v2_q    <= 1'b0;
      d2_q    <= '0;
      e2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      v1_q    <= v1_d;
      d1_q    <= d1_d;
      e1_q    <= e1_d;
      v2_q    <= v2_d;
      d2_q    <= d2_d;
      e2_q    <= e2_d;
    end
  end
  // array: zero sweep during INIT, merged in-range writes during RUN
  always_ff @(posedge clk) begin
    if (!rst && state_q == INIT) mem[cnt_q] <= '0;
    else if (!rst && acc && wr_enb && in_rng) mem[addr] <= merged;
  end
  assign ready    = state_q == RUN;
  assign rd_valid = RD_LAT == 2 ? v2_q : v1_q;
  assign rd_data  = RD_LAT == 2 ? d2_q : d1_q;
  assign addr_err = RD_LAT == 2 ? e2_q : e1_q;
endmodule

// File: tb/tb_sp_mem_pipe.sv
// tb_sp_mem_pipe: scoreboard bench driving a READ_FIRST/lat-1 and a WRITE_FIRST/lat-2 instance in lockstep
module tb_sp_mem_pipe;
  localparam int DW = 32, DEPTH = 12, AW = 4;
  logic clk = 0, rst = 1, en = 0, wr_enb = 0;
  logic [3:0] byte_enb = '0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic rdy0, rdy1, v0, v1, e0, e1;
  logic [DW-1:0] d0, d1, last0 = '0, last1 = '0;
  typedef struct {logic [DW-1:0] d; logic e; int c;} exp_t;
  exp_t q0[$], q1[$];
  exp_t x0, x1;
  logic [DW-1:0] model [DEPTH];
  int checks = 0, failures = 0, cyc = 0;

  sp_mem_pipe #(.DATA_W(DW), .DEPTH(DEPTH), .RD_LAT(1), .RDW_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .wr_enb(wr_enb), .byte_enb(byte_enb), .addr(addr),
    .wr_data(wr_data), .ready(rdy0), .rd_data(d0), .rd_valid(v0), .addr_err(e0));
  sp_mem_pipe #(.DATA_W(DW), .DEPTH(DEPTH), .RD_LAT(2), .RDW_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .wr_enb(wr_enb), .byte_enb(byte_enb), .addr(addr),
    .wr_data(wr_data), .ready(rdy1), .rd_data(d1), .rd_valid(v1), .addr_err(e1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (v0) begin
      if (q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL lat1_unexpected actual=%0h required=none", d0);
      end else begin
        x0 = q0.pop_front();
        chk("lat1_data", d0, x0.d);
        chk("lat1_err", e0, x0.e);
        chk("lat1_cycle", cyc, x0.c);
      end
      last0 = d0;
    end else if (rst) last0 = '0;
    else chk("lat1_hold", d0, last0);
  end

  always @(negedge clk) begin
    if (v1) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL lat2_unexpected actual=%0h required=none", d1);
      end else begin
        x1 = q1.pop_front();
        chk("lat2_data", d1, x1.d);
        chk("lat2_err", e1, x1.e);
        chk("lat2_cycle", cyc, x1.c);
      end
      last1 = d1;
    end else if (rst) last1 = '0;
    else chk("lat2_hold", d1, last1);
  end

  task automatic issue(logic w, logic [3:0] be, logic [AW-1:0] a, logic [DW-1:0] d);
    logic [DW-1:0] o, m;
    exp_t x;
    en = 1; wr_enb = w; byte_enb = be; addr = a; wr_data = d;
    @(posedge clk); #1;
    o = '0; m = '0;
    if (a < DEPTH) begin
      o = model[a];
      m = o;
      for (int i = 0; i < 4; i++) if (w && be[i]) m[8*i +: 8] = d[8*i +: 8];
    end
    x.e = a >= DEPTH;
    x.d = o; x.c = cyc; q0.push_back(x);
    x.d = w ? m : o; x.c = cyc + 1; q1.push_back(x);
    if (a < DEPTH && w) model[a] = m;
  endtask

  task automatic idle();
    en = 0;
    @(posedge clk); #1;
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) issue(1'b0, 4'hF, AW'(a), $urandom);
  endtask

  task automatic do_reset(int n);
    int k;
    rst = 1; en = 0;
    repeat (n) @(posedge clk);
    #1;
    q0.delete(); q1.delete();
    for (int a = 0; a < DEPTH; a++) model[a] = '0;
    chk("rst_ready0", rdy0, 0); chk("rst_ready1", rdy1, 0);
    chk("rst_valid0", v0, 0); chk("rst_valid1", v1, 0);
    chk("rst_data0", d0, 0); chk("rst_data1", d1, 0);
    chk("rst_err0", e0, 0); chk("rst_err1", e1, 0);
    rst = 0;
    en = 1; wr_enb = 1; byte_enb = 4'hF; addr = '0; wr_data = '1;
    k = 0;
    while (!rdy0 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    en = 0;
    chk("ready_edges", k, DEPTH);
    chk("ready_lat2", rdy1, 1);
  endtask

  initial begin
    do_reset(3);
    read_all();
    issue(1'b1, 4'hF, 4'd5, 32'hAABBCCDD);
    issue(1'b1, 4'h5, 4'd5, 32'h11223344);
    issue(1'b0, 4'h0, 4'd5, 32'h0);
    idle();
    issue(1'b1, 4'hF, 4'd3, 32'h12345678);
    idle();
    issue(1'b1, 4'hF, 4'd3, 32'hCAFEF00D);
    issue(1'b0, 4'h0, 4'd3, 32'h0);
    idle();
    issue(1'b0, 4'h0, 4'd1, 32'h0);
    issue(1'b0, 4'h0, 4'd2, 32'h0);
    issue(1'b0, 4'h0, 4'd3, 32'h0);
    idle();
    issue(1'b1, 4'hF, 4'd13, 32'hFFFFFFFF);
    issue(1'b0, 4'h0, 4'd15, 32'h0);
    read_all();
    issue(1'b1, 4'h0, 4'd7, 32'hDEADBEEF);
    issue(1'b0, 4'h0, 4'd7, 32'h0);
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) idle();
      else issue(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom_range(0, 15)), $urandom);
    end
    read_all();
    issue(1'b1, 4'hF, 4'd4, 32'h5A5A5A5A);
    issue(1'b0, 4'h0, 4'd4, 32'h0);
    do_reset(2);
    read_all();
    repeat (4) idle();
    chk("drain_lat1", q0.size(), 0);
    chk("drain_lat2", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
